dac_offset_cal: RTL

- Black-level (dark offset) calibration controller that owns the offset/gain inputs of the serial DAC block. Both run on clk_100M.
- Performs a 16-step successive-approximation search on the offset code. Each trial waits for the DAC update to settle, then averages dark (optical-black) ADC samples and compares the mean against a target.
- Outside calibration it drives host-supplied values (manual) or the calibrated offset (auto).

---
 rtl/dac_ctrl_pkg.sv | 16 +
 rtl/dark_accum.sv | 54 +++++
 rtl/dac_offset_cal.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dac_ctrl_pkg.sv
// Shared types and widths for the DAC offset calibration slice.
package dac_ctrl_pkg;

  localparam int DAC_W = 16;
  localparam int ADC_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    TRIAL,
    SETTLE,
    ACCUM,
    DECIDE,
    FINISH
  } cal_state_t;

endpackage

// File: rtl/dark_accum.sv
// Dark-sample accumulator: sample counter, running sum and inter-sample
// timeout watchdog for one calibration trial.
module dark_accum
  import dac_ctrl_pkg::*;
#(
  parameter int AVG_LOG2       = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk_100M,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      enable,
  input  logic                      sample,
  input  logic [ADC_W-1:0]          data,
  output logic [ADC_W+AVG_LOG2-1:0] sum_out,
  output logic                      full,
  output logic                      timeout
);

  localparam int SUM_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(2 ** AVG_LOG2);
  localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             accept;

  // Once the trial has its samples, further strobes are dropped.
  assign full    = (cnt == N_SAMPLES);
  assign accept  = enable && sample && !full;
  assign timeout = enable && !full && !accept && (tmo_cnt == '0);

  // Sum/count on accepted samples; watchdog reloads on every accepted sample.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      sum_out <= '0;
      tmo_cnt <= TMO_LOAD;
    end else if (clear) begin
      cnt     <= '0;
      sum_out <= '0;
      tmo_cnt <= TMO_LOAD;
    end else if (accept) begin
      cnt     <= cnt + CNT_W'(1);
      sum_out <= sum_out + SUM_W'(data);
      tmo_cnt <= TMO_LOAD;
    end else if (enable && !full && tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - TMO_W'(1);
    end
  end

endmodule

// File: rtl/dac_offset_cal.sv
// Black-level offset calibration: 16-step SAR search on the DAC offset
// code, averaging dark ADC samples per trial.
//
// state  | meaning
// IDLE   | outputs follow host / calibrated values, wait for start
// TRIAL  | present code | (1 << bit) to the DAC with cal_gain
// SETTLE | wait SETTLE_CYCLES for the DAC frame and analog settling
// ACCUM  | sum 2^AVG_LOG2 dark samples, watchdog running
// DECIDE | compare mean with target, keep or drop the trial bit
// FINISH | publish result, pulse done
module dac_offset_cal
  import dac_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 20000,
  parameter int AVG_LOG2       = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter bit OFFSET_POL     = 1'b0
) (
  input  logic             clk_100M,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             manual,
  input  logic [DAC_W-1:0] host_offset,
  input  logic [DAC_W-1:0] host_gain,
  input  logic [DAC_W-1:0] cal_gain,
  input  logic [ADC_W-1:0] target,
  input  logic             adc_valid,
  input  logic             adc_dark,
  input  logic [ADC_W-1:0] adc_data,
  output logic [DAC_W-1:0] offset,
  output logic [DAC_W-1:0] gain,
  output logic             busy,
  output logic             done,
  output logic [DAC_W-1:0] cal_offset,
  output logic             cal_valid,
  output logic             error
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int BIT_W = $clog2(DAC_W);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

  cal_state_t                state, state_nxt;
  logic [DAC_W-1:0]          code;
  logic [DAC_W-1:0]          trial;
  logic [BIT_W-1:0]          bit_idx;
  logic [SET_W-1:0]          settle_cnt;
  logic [ADC_W+AVG_LOG2-1:0] acc_sum;
  logic [ADC_W-1:0]          mean;
  logic                      acc_clear, acc_full, acc_timeout, keep;

  assign trial = code | (DAC_W'(1) << bit_idx);
  assign mean  = ADC_W'(acc_sum >> AVG_LOG2);
  assign keep  = OFFSET_POL ? (mean >= target) : (mean <= target);

  dark_accum #(
    .AVG_LOG2      (AVG_LOG2),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_dark_accum (
    .clk_100M(clk_100M),
    .rst_n   (rst_n),
    .clear   (acc_clear),
    .enable  (state == ACCUM),
    .sample  (adc_valid & adc_dark),
    .data    (adc_data),
    .sum_out (acc_sum),
    .full    (acc_full),
    .timeout (acc_timeout)
  );

  // State register.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort wins over everything outside IDLE.
  always_comb begin
    state_nxt = state;
    acc_clear = 1'b0;
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:   if (start) state_nxt = TRIAL;
        TRIAL:  state_nxt = SETTLE;
        SETTLE: if (settle_cnt == '0) begin
                  state_nxt = ACCUM;
                  acc_clear = 1'b1;
                end
        ACCUM:  if (acc_timeout)   state_nxt = IDLE;
                else if (acc_full) state_nxt = DECIDE;
        DECIDE: state_nxt = (bit_idx == '0) ? FINISH : TRIAL;
        FINISH: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath and registered outputs; DAC inputs move only in IDLE or TRIAL.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      offset     <= '0;
      gain       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cal_offset <= '0;
      cal_valid  <= 1'b0;
      error      <= 1'b0;
      code       <= '0;
      bit_idx    <= '0;
      settle_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            offset <= (manual || !cal_valid) ? host_offset : cal_offset;
            gain   <= host_gain;
            if (start) begin
              busy    <= 1'b1;
              error   <= 1'b0;
              code    <= '0;
              bit_idx <= BIT_W'(DAC_W - 1);
            end
          end
          TRIAL: begin
            offset     <= trial;
            gain       <= cal_gain;
            settle_cnt <= SETTLE_LOAD;
          end
          SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - SET_W'(1);
          ACCUM: if (acc_timeout) begin
            error <= 1'b1;
            busy  <= 1'b0;
          end
          DECIDE: begin
            if (keep) code <= trial;
            if (bit_idx != '0) bit_idx <= bit_idx - BIT_W'(1);
          end
          FINISH: begin
            cal_offset <= code;
            cal_valid  <= 1'b1;
            done       <= 1'b1;
            busy       <= 1'b0;
          end
          default: busy <= 1'b0;
        endcase
      end
    end
  end

endmodule
